score_display_scanner: RTL
==========================

// Module: score_display_scanner
// PURPOSE
//  Drives the board's 4-digit common-anode 7-segment display by time-multiplexing digits.
//  Latches up to four BCD score digits from game logic and scans them one at a time.
//  For the active digit it drives one active-low anode and the active-low a..g segments,
//  with a blanking guard between digits to prevent ghosting.
//  New digit values are applied only at frame boundaries, so a frame never mixes old and new.
// PARAMETERS
//  CLK_DIV      50000  clocks each digit is lit (SHOW dwell); must be >= 2
//  GUARD_CYCLES 16     clocks all anodes are off between digits; must be >= 1
//  BLINK_DIV    250    frames per blink half-period (used only with SCAN_BLINK_EN)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  Digits     in   16  BCD digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3
//  DigitEn    in   4   per-digit enable; 0 = anode never driven for that digit
//  Load       in   1   1-cycle strobe; captures Digits/DigitEn into the staging register
//  Blink      in   4   per-digit blink select (port exists only with SCAN_BLINK_EN)
//  Leds       out  7   [0:6] = a..g, active-low, registered
//  adrive     out  4   anode drive, active-low, one-hot-low or all-ones, registered
//  FrameDone  out  1   1-cycle pulse when digit3 finishes its dwell (frame boundary)
//  Pending    out  1   1 while staged data is waiting for the next frame boundary
// BEHAVIOUR
//  - Reset values: adrive=4'b1111, Leds=7'b111_1111, FrameDone=0, Pending=0.
//    Internal state after reset: state=GUARD, idx=3, prescaler=0.
//    Shadow digits = 0 and shadow DigitEn = 4'b0001, so the display shows a single "0".
//  - FSM has two states: SHOW and GUARD. idx is a 2-bit digit index.
//  - SHOW: prescaler counts 0..CLK_DIV-1.
//    At CLK_DIV-1: go to GUARD and clear prescaler; outputs become blank on that same edge.
//  - GUARD: adrive=4'b1111, Leds=7'b111_1111. Prescaler counts 0..GUARD_CYCLES-1.
//    At GUARD_CYCLES-1: idx <= idx+1 (3 wraps to 0), go to SHOW.
//    On that edge, drive adrive[idx_next]=0 if shadow DigitEn[idx_next]=1, else 4'b1111.
//  - Segment decode (active-low): 0=000_0001 1=100_1111 2=001_0010 3=000_0110 4=100_1100
//    5=010_0100 6=010_0000 7=000_1111 8=000_0000 9=000_0100.
//    Values 10-15 give 7'b111_1111 with the anode still driven.
//  - Output latency: adrive and Leds always change on the same edge; no stale segments under a new anode.
//  - Frame boundary = the SHOW->GUARD edge while idx=3. On that edge:
//    FrameDone=1 for one cycle.
//    If Pending=1: shadow <= staging and Pending <= 0.
//  - Load: staging <= {Digits, DigitEn} and Pending <= 1 on the next edge.
//    A Load coinciding with the frame boundary: the shadow copy uses the pre-edge staging value.
//    The new data stays staged, Pending stays 1, and it applies at the following boundary.
//    Back-to-back Loads within a frame: last write wins.
//  - DigitEn all zero: adrive stays 4'b1111 in all states; scanning and FrameDone continue.
//  - Reset asserted mid-scan: the next edge restores all reset values; staged data is discarded.
// CONFIGURATION
//  SCAN_BLINK_EN defined:
//    - Adds the Blink port and a frame counter.
//    - blink_phase toggles every BLINK_DIV frame boundaries; reset value is 0.
//    - While blink_phase=1, digits with shadow Blink[i]=1 keep adrive[i]=1 during SHOW.
//    - Blink is staged and shadowed together with Digits and DigitEn.
//  SCAN_BLINK_EN undefined: no Blink port, no blink counter; behaviour exactly as above.
// TESTING (sim params: CLK_DIV=4, GUARD_CYCLES=2, BLINK_DIV=2)
//  1. Reset 3 cycles, release.
//     -> adrive=1111 and Leds=1111111 for 2 cycles.
//     -> Then adrive=1110, Leds=0000001 for 4 cycles.
//     -> Digits 1-3 never drive an anode.
//  2. Load Digits=16'h1234, DigitEn=1111.
//     -> Pending=1 until the next FrameDone.
//     -> Next frame shows adrive 1110/1101/1011/0111 with Leds 100_1100/000_0110/001_0010/100_1111.
//     -> Each digit is lit 4 cycles with 2 blank cycles between digits.
//  3. Load 16'h00A5 with DigitEn=0011.
//     -> Digit0 shows 010_0100; digit1 has anode on with Leds=1111111.
//     -> adrive[3:2] stay 1 for the whole frame.
//  4. Pulse Load exactly on the FrameDone cycle.
//     -> The old staging applies at this boundary; the new data applies one frame later.
//     -> Pending stays 1 across the boundary.
//  5. Assert reset mid-SHOW of digit2 with Pending=1.
//     -> Next edge: adrive=1111, Pending=0, and the display returns to the single "0".
//  6. (SCAN_BLINK_EN) Blink=0001, DigitEn=1111.
//     -> Digit0's anode is off for 2 frames, then on for 2 frames, alternating.
//     -> Digits 1-3 are unaffected.

Source files
------------

// File: rtl/score_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with frame-aligned digit updates.
// Optional per-digit blinking is enabled by defining SCAN_BLINK_EN.
module score_display_scanner #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned BLINK_DIV    = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Digits,
  input  logic [3:0]  DigitEn,
  input  logic        Load,
`ifdef SCAN_BLINK_EN
  input  logic [3:0]  Blink,
`endif
  output logic [0:6]  Leds,
  output logic [3:0]  adrive,
  output logic        FrameDone,
  output logic        Pending
);

  localparam int unsigned MAXDIV = (CLK_DIV > GUARD_CYCLES) ? CLK_DIV : GUARD_CYCLES;
  localparam int unsigned PW     = $clog2(MAXDIV) + 1;

  if (CLK_DIV < 2 || GUARD_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_check
    $error("score_display_scanner: invalid CLK_DIV/GUARD_CYCLES/BLINK_DIV");
  end

  typedef enum logic {GUARD, SHOW} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [PW-1:0] presc;
  logic [15:0]   stg_digits, shd_digits;
  logic [3:0]    stg_en, shd_en;
  logic [1:0]    idx_next;
  logic [3:0]    digit_next;
  logic [3:0]    anode_next;

`ifdef SCAN_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV) + 1;
  logic [3:0]    stg_blink, shd_blink;
  logic [BW-1:0] frame_cnt;
  logic          blink_phase;
`endif

  function automatic logic [0:6] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b000_0001;
      4'd1:    seg_decode = 7'b100_1111;
      4'd2:    seg_decode = 7'b001_0010;
      4'd3:    seg_decode = 7'b000_0110;
      4'd4:    seg_decode = 7'b100_1100;
      4'd5:    seg_decode = 7'b010_0100;
      4'd6:    seg_decode = 7'b010_0000;
      4'd7:    seg_decode = 7'b000_1111;
      4'd8:    seg_decode = 7'b000_0000;
      4'd9:    seg_decode = 7'b000_0100;
      default: seg_decode = 7'b111_1111;
    endcase
  endfunction

  // Anode and segments for the next digit are precomputed so both land on the same edge.
  always_comb begin
    idx_next   = idx + 2'd1;
    digit_next = shd_digits[{idx_next, 2'b00} +: 4];
    anode_next = 4'b1111;
    if (shd_en[idx_next]) anode_next = ~(4'b0001 << idx_next);
`ifdef SCAN_BLINK_EN
    if (blink_phase && shd_blink[idx_next]) anode_next = 4'b1111;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GUARD;
      idx        <= 2'd3;
      presc      <= '0;
      adrive     <= '1;
      Leds       <= '1;
      FrameDone  <= 1'b0;
      Pending    <= 1'b0;
      stg_digits <= '0;
      stg_en     <= '0;
      shd_digits <= '0;
      shd_en     <= 4'b0001;
`ifdef SCAN_BLINK_EN
      stg_blink   <= '0;
      shd_blink   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
`endif
    end else begin
      FrameDone <= 1'b0;
      case (state)
        SHOW: begin
          if (presc == PW'(CLK_DIV - 1)) begin
            state  <= GUARD;
            presc  <= '0;
            adrive <= '1;
            Leds   <= '1;
            if (idx == 2'd3) begin
              FrameDone <= 1'b1;
              if (Pending) begin
                shd_digits <= stg_digits;
                shd_en     <= stg_en;
`ifdef SCAN_BLINK_EN
                shd_blink  <= stg_blink;
`endif
                Pending    <= 1'b0;
              end
`ifdef SCAN_BLINK_EN
              if (frame_cnt == BW'(BLINK_DIV - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
`endif
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        GUARD: begin
          adrive <= '1;
          Leds   <= '1;
          if (presc == PW'(GUARD_CYCLES - 1)) begin
            state  <= SHOW;
            presc  <= '0;
            idx    <= idx_next;
            adrive <= anode_next;
            Leds   <= seg_decode(digit_next);
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= GUARD;
      endcase
      // Placed after the boundary clear so a Load on the boundary edge keeps Pending set.
      if (Load) begin
        stg_digits <= Digits;
        stg_en     <= DigitEn;
`ifdef SCAN_BLINK_EN
        stg_blink  <= Blink;
`endif
        Pending    <= 1'b1;
      end
    end
  end

endmodule
